// File: rtl/fpro_bus_pkg.sv
// Shared widths, FSM state type and command record for the FPro MMIO bus initiator.
package fpro_bus_pkg;

  localparam int MMIO_AW = 21;
  localparam int MMIO_DW = 32;
  localparam int CMD_W   = 1 + MMIO_AW + MMIO_DW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic               wr;
    logic [MMIO_AW-1:0] addr;
    logic [MMIO_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mmio_cmd_fifo.sv
// First-word fall-through command FIFO; pointers carry one extra bit so full and empty differ.
module mmio_cmd_fifo #(
  parameter int W  = 54,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Guard against an over-push or under-pop corrupting the pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpro_bus_master.sv
// FPro MMIO bus initiator: queued single-word commands, registered one-cycle strobes, held read response.
//   state  | meaning
//   IDLE   | waiting for a queued command; pops and loads the bus registers
//   STROBE | one-cycle cs/wr or cs/rd on the bus; read data captured at its closing edge
//   RESP   | read data held on the response port until the consumer takes it
module fpro_bus_master
  import fpro_bus_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr,
  input  logic [MMIO_AW-1:0] cmd_addr,
  input  logic [MMIO_DW-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MMIO_DW-1:0] rsp_rdata,
  output logic               busy,
  output logic               mmio_cs,
  output logic               mmio_wr,
  output logic               mmio_rd,
  output logic [MMIO_AW-1:0] mmio_addr,
  output logic [MMIO_DW-1:0] mmio_wr_data,
  input  logic [MMIO_DW-1:0] mmio_rd_data
);

  state_t             state_q, state_d;
  logic               mmio_cs_q, mmio_cs_d;
  logic               mmio_wr_q, mmio_wr_d;
  logic               mmio_rd_q, mmio_rd_d;
  logic [MMIO_AW-1:0] mmio_addr_q, mmio_addr_d;
  logic [MMIO_DW-1:0] mmio_wr_data_q, mmio_wr_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MMIO_DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic fifo_full, fifo_empty, fifo_push, fifo_pop;
  cmd_t cmd_in, head;

  assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_push = cmd_valid && !fifo_full;
  assign cmd_ready = !fifo_full;

  mmio_cmd_fifo #(
    .W  (CMD_W),
    .AW (FIFO_AW)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (cmd_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (head)
  );

  always_comb begin
    state_d        = state_q;
    fifo_pop       = 1'b0;
    mmio_cs_d      = 1'b0;
    mmio_wr_d      = 1'b0;
    mmio_rd_d      = 1'b0;
    mmio_addr_d    = '0;
    mmio_wr_data_d = '0;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          mmio_cs_d      = 1'b1;
          mmio_wr_d      = head.wr;
          mmio_rd_d      = !head.wr;
          mmio_addr_d    = head.addr;
          mmio_wr_data_d = head.wr ? head.wdata : '0;
          state_d        = STROBE;
        end
      end
      STROBE: begin
        // Bus registers fall back to zero from the defaults, closing the strobe.
        if (mmio_rd_q) begin
          rsp_rdata_d = mmio_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mmio_cs_q      <= 1'b0;
      mmio_wr_q      <= 1'b0;
      mmio_rd_q      <= 1'b0;
      mmio_addr_q    <= '0;
      mmio_wr_data_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      mmio_cs_q      <= mmio_cs_d;
      mmio_wr_q      <= mmio_wr_d;
      mmio_rd_q      <= mmio_rd_d;
      mmio_addr_q    <= mmio_addr_d;
      mmio_wr_data_q <= mmio_wr_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign mmio_cs      = mmio_cs_q;
  assign mmio_wr      = mmio_wr_q;
  assign mmio_rd      = mmio_rd_q;
  assign mmio_addr    = mmio_addr_q;
  assign mmio_wr_data = mmio_wr_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpro_bus_master.sv
// Bench for fpro_bus_master: vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_fpro_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [20:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        busy, mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data;

  fpro_bus_master #(.FIFO_AW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  // Slot model: combinational read data, a poison value when not being read.
  function automatic logic [31:0] slot_fn(input logic [20:0] a);
    if (a == 21'h060) return 32'h1234_5678;
    return {a[10:0], a} ^ 32'hC3A5_0F1E;
  endfunction
  assign mmio_rd_data = mmio_rd ? slot_fn(mmio_addr) : 32'h0BAD_F00D;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [20:0] a, input logic [31:0] d);
    int n = 0;
    cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) check("send_timeout", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Reference model: ordered queue of accepted commands and of expected read data.
  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
  } cmd_rec_t;

  cmd_rec_t    exp_cmd[$];
  logic [31:0] exp_rsp[$];
  logic        rsp_pending = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata = '0;

  always @(negedge clk) begin
    cmd_rec_t rec;
    logic     proto_ok;
    if (!reset_n) begin
      check("reset_outs", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
                           rsp_valid, rsp_rdata, busy, cmd_ready}, 128'd1);
      exp_cmd.delete();
      exp_rsp.delete();
      rsp_pending = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      proto_ok = !(mmio_wr && mmio_rd) && !(mmio_cs && rsp_valid) &&
                 (mmio_cs ? (mmio_wr ^ mmio_rd)
                          : ({mmio_wr, mmio_rd, mmio_addr, mmio_wr_data} == '0));
      check("bus_proto", proto_ok, 1);
      check("busy", busy, (exp_cmd.size() > 0) || rsp_pending);
      check("rsp_valid", rsp_valid, rsp_pending);
      if (prev_hold) check("rsp_hold", {rsp_valid, rsp_rdata}, {1'b1, prev_rdata});
      if (mmio_cs) begin
        if (exp_cmd.size() == 0) check("unexpected_strobe", mmio_cs, 0);
        else begin
          rec = exp_cmd.pop_front();
          check("strobe_wr", mmio_wr, rec.wr);
          check("strobe_addr", mmio_addr, rec.addr);
          if (rec.wr) check("strobe_wdata", mmio_wr_data, rec.wdata);
          else begin
            exp_rsp.push_back(slot_fn(rec.addr));
            rsp_pending = 1'b1;
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", rsp_valid, 0);
        else check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
        rsp_pending = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        rec.wr = cmd_wr; rec.addr = cmd_addr; rec.wdata = cmd_wdata;
        exp_cmd.push_back(rec);
      end
      prev_hold  = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
    end
  end

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_strobe_k;
    int          exp_rsp_k;
    string       name;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          sk, rk, ns, nr, n, sent;
    logic [31:0] got;
    logic        acc;
    int          sp[$];

    vecs[0] = '{1'b1, 21'h042,    32'hDEAD_BEEF, 32'h0,                2, -1, "wr_042"};
    vecs[1] = '{1'b0, 21'h060,    32'h0,         32'h1234_5678,        2,  3, "rd_060"};
    vecs[2] = '{1'b1, 21'h1FFFFF, 32'hFFFF_FFFF, 32'h0,                2, -1, "wr_max"};
    vecs[3] = '{1'b0, 21'h7FF,    32'h5555_5555, slot_fn(21'h7FF),     2,  3, "rd_7ff"};
    vecs[4] = '{1'b1, 21'h000,    32'h0000_0000, 32'h0,                2, -1, "wr_zero"};
    vecs[5] = '{1'b0, 21'h100000, 32'h0,         slot_fn(21'h100000),  2,  3, "rd_top"};

    // Reset with random inputs toggling.
    repeat (4) begin
      tick();
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_addr  = 21'($urandom);
      cmd_wdata = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #2 reset_n = 1'b1;

    // Single-transaction vectors with the consumer always ready.
    foreach (vecs[i]) begin
      tick();
      cmd_wr = vecs[i].wr; cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata; cmd_valid = 1'b1;
      @(negedge clk);
      check({vecs[i].name, "_ready"}, cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      sk = -1; rk = -1; ns = 0; nr = 0; got = '0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (mmio_cs) begin ns++; if (sk < 0) sk = k; end
        if (rsp_valid) begin nr++; if (rk < 0) rk = k; got = rsp_rdata; end
      end
      check({vecs[i].name, "_strobe_at"}, sk, vecs[i].exp_strobe_k);
      check({vecs[i].name, "_strobe_cnt"}, ns, 1);
      check({vecs[i].name, "_rsp_at"}, rk, vecs[i].exp_rsp_k);
      check({vecs[i].name, "_rsp_cnt"}, nr, vecs[i].wr ? 0 : 1);
      if (!vecs[i].wr) check({vecs[i].name, "_rdata"}, got, vecs[i].exp_rdata);
    end

    // Response backpressure with three writes queued behind the read.
    tick();
    rsp_ready = 1'b0;
    send(1'b0, 21'h060, 32'h0);
    send(1'b1, 21'h041, 32'hA000_0001);
    send(1'b1, 21'h042, 32'hA000_0002);
    send(1'b1, 21'h043, 32'hA000_0003);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_rdata, mmio_cs}, {1'b1, 32'h1234_5678, 1'b0});
    end
    tick();
    rsp_ready = 1'b1;
    sp.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mmio_cs) sp.push_back(k);
    end
    check("bp_nstrobe", sp.size(), 3);
    if (sp.size() == 3) check("bp_spacing", {sp[0], sp[1], sp[2]}, {32'd3, 32'd5, 32'd7});

    // FIFO fill behind a held read response.
    tick();
    rsp_ready = 1'b0;
    send(1'b0, 21'h0A5, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check("fill_rsp_wait", rsp_valid, 1);
    tick();
    send(1'b1, 21'h081, 32'hB000_0001);
    send(1'b0, 21'h082, 32'h0);
    send(1'b1, 21'h083, 32'hB000_0003);
    send(1'b0, 21'h084, 32'h0);
    cmd_wr = 1'b1; cmd_addr = 21'h085; cmd_wdata = 32'hB000_0005; cmd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("fill_full", {cmd_ready, busy}, {1'b0, 1'b1});
    end
    tick();
    rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
    check("fill_fifth_wait", n, 3);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    check("fill_drain", {busy, 32'(exp_cmd.size()), 32'(exp_rsp.size())}, 0);

    // Reset asserted during the first strobe of a three-write burst.
    tick();
    fork
      begin
        send(1'b1, 21'h0C1, 32'h1111_1111);
        send(1'b1, 21'h0C2, 32'h2222_2222);
        send(1'b1, 21'h0C3, 32'h3333_3333);
      end
      begin
        int m = 0;
        do begin @(negedge clk); m++; end while (!mmio_cs && m < 50);
        check("rst_first_strobe", {mmio_cs, mmio_addr}, {1'b1, 21'h0C1});
        #2 reset_n = 1'b0;
        #1 check("rst_async", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, busy, cmd_ready}, 128'd1);
      end
    join
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    ns = 0;
    repeat (10) begin
      @(negedge clk);
      if (mmio_cs) ns++;
    end
    check("rst_no_replay", {ns, busy}, 0);

    // Random traffic with random response backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 4000 && sent < 80; cyc++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin cmd_valid = 1'b0; sent++; end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && sent < 80 && $urandom_range(0, 1) == 1) begin
        cmd_wr    = 1'($urandom_range(0, 1));
        cmd_addr  = ($urandom_range(0, 3) == 0) ? 21'h060 : 21'($urandom);
        cmd_wdata = $urandom;
        cmd_valid = 1'b1;
      end
    end
    check("rand_sent", sent, 80);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    check("rand_drain", {busy, 32'(exp_cmd.size()), 32'(exp_rsp.size())}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
